// File: rtl/branch_pc_sequencer.sv
// branch_pc_sequencer
// Owns the program counter and walks every instruction through the five
// sequential phases IF, ID, EX, MEM and WB. The comparator's equality flag is
// sampled once, in EX, to resolve a BEQ. The PC moves in WB, either to the
// next sequential word or to the branch target. Per-phase enables for fetch,
// data memory and the register file are decoded straight from the phase
// register, so they are glitch-free and correct during reset.
module branch_pc_sequencer #(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter logic [XLEN-1:0] PC_STEP  = XLEN'(4)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            eq,
   input  logic            branch,
   input  logic            mem_op,
   input  logic [XLEN-1:0] imm,
   input  logic            mem_ready,
   input  logic            halt_req,
   output logic [XLEN-1:0] pc,
   output logic [2:0]      phase,
   output logic            fetch_en,
   output logic            dmem_en,
   output logic            wb_en,
   output logic            branch_taken,
   output logic            halted
);

   // Phase codes double as the externally visible phase number.
   localparam logic [2:0] PH_IF   = 3'd0;
   localparam logic [2:0] PH_ID   = 3'd1;
   localparam logic [2:0] PH_EX   = 3'd2;
   localparam logic [2:0] PH_MEM  = 3'd3;
   localparam logic [2:0] PH_WB   = 3'd4;
   localparam logic [2:0] PH_HALT = 3'd5;

   logic [2:0]      phase_q, phase_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            branch_taken_q, branch_taken_d;

   // The offset is held in halfword units. The top bit is shifted out, and
   // the add wraps modulo 2^XLEN, so negative offsets work as two's complement.
   logic [XLEN-1:0] branch_offset;
   logic [XLEN-1:0] branch_target;
   logic [XLEN-1:0] seq_target;

   assign branch_offset = imm << 1;
   assign branch_target = pc_q + branch_offset;
   assign seq_target    = pc_q + PC_STEP;

   // Next-state logic for the instruction cycle, the branch decision and the PC.
   always_comb begin
      phase_d        = phase_q;
      pc_d           = pc_q;
      branch_taken_d = branch_taken_q;
      case (phase_q)
         PH_IF: begin
            if (mem_ready) begin
               phase_d = halt_req ? PH_HALT : PH_ID;
            end
         end
         PH_ID: begin
            phase_d = PH_EX;
         end
         PH_EX: begin
            branch_taken_d = branch & eq;
            phase_d        = PH_MEM;
         end
         PH_MEM: begin
            if (!mem_op || mem_ready) begin
               phase_d = PH_WB;
            end
         end
         PH_WB: begin
            pc_d           = branch_taken_q ? branch_target : seq_target;
            branch_taken_d = 1'b0;
            phase_d        = PH_IF;
         end
         PH_HALT: begin
            phase_d = PH_HALT;
         end
         default: begin
            phase_d = PH_IF;
         end
      endcase
   end

   // State registers. Reset is asynchronous, so an instruction stalled in
   // any phase is abandoned immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q        <= PH_IF;
         pc_q           <= RESET_PC;
         branch_taken_q <= 1'b0;
      end else begin
         phase_q        <= phase_d;
         pc_q           <= pc_d;
         branch_taken_q <= branch_taken_d;
      end
   end

   assign pc           = pc_q;
   assign phase        = phase_q;
   assign branch_taken = branch_taken_q;
   assign fetch_en     = (phase_q == PH_IF);
   assign dmem_en      = (phase_q == PH_MEM) && mem_op;
   assign wb_en        = (phase_q == PH_WB);
   assign halted       = (phase_q == PH_HALT);

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// tb_branch_pc_sequencer
// Drives whole instructions, each with a planned number of stall cycles. For
// every cycle the reference model pushes the expected visible state into a
// queue. A monitor on the falling edge pops one entry per cycle and compares
// it against the DUT.
module tb_branch_pc_sequencer;

   localparam int XLEN = 64;
   localparam logic [2:0] P_IF   = 3'd0;
   localparam logic [2:0] P_ID   = 3'd1;
   localparam logic [2:0] P_EX   = 3'd2;
   localparam logic [2:0] P_MEM  = 3'd3;
   localparam logic [2:0] P_WB   = 3'd4;
   localparam logic [2:0] P_HALT = 3'd5;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            eq = 1'b0;
   logic            branch = 1'b0;
   logic            mem_op = 1'b0;
   logic [XLEN-1:0] imm = '0;
   logic            mem_ready = 1'b0;
   logic            halt_req = 1'b0;
   logic [XLEN-1:0] pc;
   logic [2:0]      phase;
   logic            fetch_en, dmem_en, wb_en, branch_taken, halted;

   typedef struct {
      int unsigned     tag;
      logic [2:0]      phase;
      logic            fetch_en;
      logic            dmem_en;
      logic            wb_en;
      logic            branch_taken;
      logic            halted;
      logic [XLEN-1:0] pc;
   } exp_t;

   exp_t            exp_q[$];
   int              n_compared = 0;
   int              n_mismatched = 0;
   int unsigned     tag_cnt = 0;
   logic [XLEN-1:0] m_pc = '0;
   logic            m_bt = 1'b0;

   branch_pc_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .eq           (eq),
      .branch       (branch),
      .mem_op       (mem_op),
      .imm          (imm),
      .mem_ready    (mem_ready),
      .halt_req     (halt_req),
      .pc           (pc),
      .phase        (phase),
      .fetch_en     (fetch_en),
      .dmem_en      (dmem_en),
      .wb_en        (wb_en),
      .branch_taken (branch_taken),
      .halted       (halted)
   );

   always #5 clk = ~clk;

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Record what the outputs must show during the current cycle.
   task automatic push_exp(input logic [2:0] ph, input logic mop);
      exp_t e;
      e.tag          = tag_cnt;
      e.phase        = ph;
      e.fetch_en     = (ph == P_IF);
      e.dmem_en      = (ph == P_MEM) && mop;
      e.wb_en        = (ph == P_WB);
      e.branch_taken = m_bt;
      e.halted       = (ph == P_HALT);
      e.pc           = m_pc;
      tag_cnt++;
      exp_q.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      n_compared++;
      if ({phase, fetch_en, dmem_en, wb_en, branch_taken, halted, pc} !==
          {e.phase, e.fetch_en, e.dmem_en, e.wb_en, e.branch_taken, e.halted, e.pc}) begin
         n_mismatched++;
         $display("[TB] FAIL cycle_%0d: got phase=%0d fe=%b de=%b wb=%b bt=%b h=%b pc=%h, want phase=%0d fe=%b de=%b wb=%b bt=%b h=%b pc=%h",
                  e.tag, phase, fetch_en, dmem_en, wb_en, branch_taken, halted, pc,
                  e.phase, e.fetch_en, e.dmem_en, e.wb_en, e.branch_taken, e.halted, e.pc);
      end
   endtask

   // Monitor: compare one expected entry per cycle, away from the rising edge.
   always @(negedge clk) begin
      if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
   end

   // One clock cycle: apply inputs just after the edge and log the expected state.
   task automatic drive_cycle(input logic [2:0] ph, input logic mr, input logic hr,
                              input logic br, input logic e_in, input logic mop,
                              input logic [XLEN-1:0] im);
      @(posedge clk);
      #1;
      mem_ready = mr;
      halt_req  = hr;
      branch    = br;
      eq        = e_in;
      mem_op    = mop;
      imm       = im;
      push_exp(ph, mop);
   endtask

   // Assert reset in the middle of a cycle, and check the outputs while it is held.
   task automatic do_reset();
      @(posedge clk);
      #2;
      reset     = 1'b1;
      mem_ready = 1'b0;
      halt_req  = 1'b0;
      m_pc      = '0;
      m_bt      = 1'b0;
      push_exp(P_IF, 1'b0);
      drive_cycle(P_IF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      @(negedge clk);
      #1;
      reset = 1'b0;
   endtask

   // One full instruction with planned stalls, then the architectural PC update.
   task automatic applyStimulus(input logic br, input logic e_in, input logic mop,
                                input logic [XLEN-1:0] im, input int if_stall,
                                input int mem_stall);
      for (int i = 0; i < if_stall; i++)
         drive_cycle(P_IF, 1'b0, rbit(), rbit(), rbit(), mop, im);
      drive_cycle(P_IF, 1'b1, 1'b0, rbit(), rbit(), mop, im);
      drive_cycle(P_ID, rbit(), rbit(), br, rbit(), mop, im);
      drive_cycle(P_EX, rbit(), rbit(), br, e_in, mop, im);
      m_bt = br & e_in;
      if (mop) begin
         for (int i = 0; i < mem_stall; i++)
            drive_cycle(P_MEM, 1'b0, rbit(), br, rbit(), mop, im);
         drive_cycle(P_MEM, 1'b1, rbit(), br, rbit(), mop, im);
      end else begin
         drive_cycle(P_MEM, rbit(), rbit(), br, rbit(), mop, im);
      end
      drive_cycle(P_WB, rbit(), rbit(), br, rbit(), mop, im);
      if (m_bt) m_pc = m_pc + im + im;
      else      m_pc = m_pc + 64'd4;
      m_bt = 1'b0;
   endtask

   // Move the PC to an arbitrary even address with a taken branch.
   task automatic jump_to(input logic [XLEN-1:0] target);
      logic [XLEN-1:0] diff;
      diff = target - m_pc;
      applyStimulus(1'b1, 1'b1, 1'b0, XLEN'($signed(diff) >>> 1), 0, 0);
   endtask

   // Halt request: ignored while the fetch is stalled, taken on mem_ready.
   task automatic do_halt(input int if_stall);
      for (int i = 0; i < if_stall; i++)
         drive_cycle(P_IF, 1'b0, 1'b1, rbit(), rbit(), 1'b0, '0);
      drive_cycle(P_IF, 1'b1, 1'b1, rbit(), rbit(), 1'b0, '0);
      for (int i = 0; i < 20; i++)
         drive_cycle(P_HALT, rbit(), rbit(), rbit(), rbit(), rbit(), {$urandom, $urandom});
   endtask

   task automatic random_instr();
      logic [XLEN-1:0] im;
      if (rbit()) im = {$urandom, $urandom};
      else        im = XLEN'($signed(32'($urandom_range(0, 64)) - 32'sd32));
      applyStimulus(rbit(), rbit(), rbit(), im, $urandom_range(0, 3), $urandom_range(0, 3));
   endtask

   // Directed scenarios first, then random traffic, then halt and recovery.
   initial begin
      do_reset();

      // Reset while the data access is stalled.
      drive_cycle(P_IF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
      drive_cycle(P_ID, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
      drive_cycle(P_EX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
      drive_cycle(P_MEM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
      do_reset();

      // Sequential step, taken branch backwards, untaken branch.
      jump_to(64'h100);
      applyStimulus(1'b0, rbit(), 1'b0, {$urandom, $urandom}, 0, 0);
      jump_to(64'h100);
      applyStimulus(1'b1, 1'b1, 1'b0, -64'sd8, 0, 0);
      jump_to(64'h100);
      applyStimulus(1'b1, 1'b0, 1'b0, -64'sd8, 0, 0);

      // Stalled memory instruction at the top of the address space wraps to 0.
      jump_to(64'hFFFF_FFFF_FFFF_FFFC);
      applyStimulus(1'b0, 1'b1, 1'b1, {$urandom, $urandom}, 3, 2);

      for (int n = 0; n < 40; n++) random_instr();

      do_halt(3);
      do_reset();
      for (int n = 0; n < 5; n++) random_instr();
      drive_cycle(P_IF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
